// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: three requesters share one RF write port, plus a busy scoreboard.
// Default arbitration is fixed priority with starvation promotion; define RF_WB_RR_EN for round-robin.
module rf_wb_arb #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        rf_write,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  input  logic        claim_valid,
  input  logic [4:0]  claim_reg,
  input  logic [4:0]  q_reg1,
  input  logic [4:0]  q_reg2,
  output logic        q_busy1,
  output logic        q_busy2
);
  localparam int NREQ = 3;  // index 0 = alu, 1 = mem, 2 = md

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  logic [NREQ-1:0] w_valid, w_gnt_raw, w_gnt;
  wb_req_t         w_req [NREQ];
  wb_req_t         w_win;
  logic            w_xfer;
  logic [31:0]     w_busy_nxt;
  logic [31:0]     r_busy;
  logic            r_wr;
  logic [4:0]      r_wr_reg;
  logic [31:0]     r_wr_data;

  assign w_valid = {md_valid, mem_valid, alu_valid};
  assign w_req[0] = '{rd: alu_reg, data: alu_data};
  assign w_req[1] = '{rd: mem_reg, data: mem_data};
  assign w_req[2] = '{rd: md_reg,  data: md_data};

`ifdef RF_WB_RR_EN
  // r_ptr names the requester where the search starts
  logic [1:0] r_ptr;

  always_comb begin
    w_gnt_raw = '0;
    case (r_ptr)
      2'd1: begin
        if (w_valid[1])      w_gnt_raw = 3'b010;
        else if (w_valid[2]) w_gnt_raw = 3'b100;
        else if (w_valid[0]) w_gnt_raw = 3'b001;
      end
      2'd2: begin
        if (w_valid[2])      w_gnt_raw = 3'b100;
        else if (w_valid[0]) w_gnt_raw = 3'b001;
        else if (w_valid[1]) w_gnt_raw = 3'b010;
      end
      default: begin
        if (w_valid[0])      w_gnt_raw = 3'b001;
        else if (w_valid[1]) w_gnt_raw = 3'b010;
        else if (w_valid[2]) w_gnt_raw = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_ptr <= 2'd0;
    else if (w_gnt[0])   r_ptr <= 2'd1;
    else if (w_gnt[1])   r_ptr <= 2'd2;
    else if (w_gnt[2])   r_ptr <= 2'd0;
  end
`else
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic [7:0]      r_starve [NREQ];
  logic [NREQ-1:0] w_prom, w_cand;

  for (genvar g = 0; g < NREQ; g++) begin : g_starve
    assign w_prom[g] = w_valid[g] && (r_starve[g] == LIM);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        r_starve[g] <= '0;
      else if (w_valid[g] && !w_gnt[g]) begin
        if (r_starve[g] != LIM) r_starve[g] <= r_starve[g] + 8'd1;
      end else
        r_starve[g] <= '0;
    end
  end

  // promoted requesters pre-empt the normal order but keep mem > md > alu among themselves
  assign w_cand = (|w_prom) ? w_prom : w_valid;

  always_comb begin
    w_gnt_raw = '0;
    if (w_cand[1])      w_gnt_raw = 3'b010;
    else if (w_cand[2]) w_gnt_raw = 3'b100;
    else if (w_cand[0]) w_gnt_raw = 3'b001;
  end
`endif

  assign w_gnt  = w_gnt_raw & {NREQ{rst}};
  assign w_xfer = |w_gnt;
  assign {md_ready, mem_ready, alu_ready} = w_gnt;

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt[i]) w_win = w_req[i];
  end

  // clear first, then claim, so a same-cycle claim leaves the reg busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer && w_win.rd != 5'd0)        w_busy_nxt[w_win.rd] = 1'b0;
    if (claim_valid && claim_reg != 5'd0)  w_busy_nxt[claim_reg] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr      <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_busy    <= '0;
    end else begin
      r_wr   <= w_xfer && (w_win.rd != 5'd0);
      r_busy <= w_busy_nxt;
      if (w_xfer) begin
        r_wr_reg  <= w_win.rd;
        r_wr_data <= w_win.data;
      end
    end
  end

  assign rf_write      = r_wr;
  assign rf_write_reg  = r_wr_reg;
  assign rf_write_data = r_wr_data;
  assign q_busy1       = r_busy[q_reg1];
  assign q_busy2       = r_busy[q_reg2];

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed bench for rf_wb_arb: reset, single write, priority/starvation (or round-robin), scoreboard, reg 0.
module tb_rf_wb_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, md_valid;
  logic [4:0]  alu_reg, mem_reg, md_reg;
  logic [31:0] alu_data, mem_data, md_data;
  logic        alu_ready, mem_ready, md_ready;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        claim_valid;
  logic [4:0]  claim_reg, q_reg1, q_reg2;
  logic        q_busy1, q_busy2;

  int vec  = 0;
  int miss = 0;

  rf_wb_arb #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .rf_write(rf_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .claim_valid(claim_valid), .claim_reg(claim_reg),
    .q_reg1(q_reg1), .q_reg2(q_reg2), .q_busy1(q_busy1), .q_busy2(q_busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdy();
    return 32'({md_ready, mem_ready, alu_ready});
  endfunction

  initial begin
    rst = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h1111;
    mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'hAAAA;
    md_valid  = 1'b1; md_reg  = 5'd4; md_data  = 32'h4444;
    claim_valid = 1'b0; claim_reg = 5'd0; q_reg1 = 5'd7; q_reg2 = 5'd0;

    // reset with all requesters valid
    #2;
    chk("rst_ready", rdy(), 32'h0);
    chk("rst_rf_write", 32'(rf_write), 32'h0);
    chk("rst_rf_reg", 32'(rf_write_reg), 32'h0);
    chk("rst_rf_data", rf_write_data, 32'h0);
    chk("rst_busy", 32'(q_busy1), 32'h0);
    tick();
    chk("rst_ready_edge", rdy(), 32'h0);
    chk("rst_rf_write_edge", 32'(rf_write), 32'h0);

    rst = 1'b1;
    #1;
`ifdef RF_WB_RR_EN
    for (int c = 0; c < 6; c++) begin
      chk("rr_grant", rdy(), 32'h1 << (c % 3));
      tick();
    end
`else
    chk("rel_first_gnt", rdy(), 32'h2);
    tick();
    chk("rel_rf_write", 32'(rf_write), 32'h1);
    chk("rel_rf_reg", 32'(rf_write_reg), 32'd3);
    chk("rel_rf_data", rf_write_data, 32'hAAAA);
`endif
    alu_valid = 1'b0; mem_valid = 1'b0; md_valid = 1'b0;
    #1;
    chk("idle_ready", rdy(), 32'h0);
    tick();
    chk("idle_no_write", 32'(rf_write), 32'h0);

    // single ALU write
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h1234;
    #1;
    chk("single_ready", rdy(), 32'h1);
    tick();
    alu_valid = 1'b0;
    chk("single_wr", 32'(rf_write), 32'h1);
    chk("single_reg", 32'(rf_write_reg), 32'd5);
    chk("single_data", rf_write_data, 32'h1234);

    // scoreboard: claim, claim+clear same cycle, lone clear
    claim_valid = 1'b1; claim_reg = 5'd7; q_reg1 = 5'd7;
    tick();
    claim_valid = 1'b0;
    chk("sb_claim", 32'(q_busy1), 32'h1);
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h77;
    claim_valid = 1'b1; claim_reg = 5'd7;
    #1;
    chk("sb_md_ready", rdy(), 32'h4);
    tick();
    claim_valid = 1'b0;
    chk("sb_claim_wins", 32'(q_busy1), 32'h1);
    chk("sb_wr1_reg", 32'(rf_write_reg), 32'd7);
    md_data = 32'h88;
    tick();
    md_valid = 1'b0;
    chk("sb_cleared", 32'(q_busy1), 32'h0);
    chk("sb_wr2_data", rf_write_data, 32'h88);
    chk("sb_wr2_wr", 32'(rf_write), 32'h1);

    // reg 0: handshake completes, no write, claim ignored
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h5;
    claim_valid = 1'b1; claim_reg = 5'd0; q_reg2 = 5'd0;
    #1;
    chk("r0_ready", rdy(), 32'h2);
    tick();
    mem_valid = 1'b0; claim_valid = 1'b0;
    chk("r0_no_write", 32'(rf_write), 32'h0);
    chk("r0_not_busy", 32'(q_busy2), 32'h0);

    // unclaimed reg still gets written
    mem_valid = 1'b1; mem_reg = 5'd12; mem_data = 32'hC0DE; q_reg2 = 5'd12;
    tick();
    mem_valid = 1'b0;
    chk("unclaimed_wr", 32'(rf_write), 32'h1);
    chk("unclaimed_reg", 32'(rf_write_reg), 32'd12);
    chk("unclaimed_busy", 32'(q_busy2), 32'h0);
    tick();

`ifndef RF_WB_RR_EN
    // plain priority: mem > md > alu
    alu_valid = 1'b1; mem_valid = 1'b1; md_valid = 1'b1;
    alu_reg = 5'd9; mem_reg = 5'd2; md_reg = 5'd10;
    #1;
    chk("prio_mem", rdy(), 32'h2);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("prio_md", rdy(), 32'h4);
    tick();
    alu_valid = 1'b0; md_valid = 1'b0;
    tick();

    // starvation: alu promoted on its 9th held cycle, md (one cycle later) on the 10th
    alu_valid = 1'b1; mem_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      logic [31:0] exp_r;
      md_valid = (c >= 2);
      #1;
      exp_r = (c == 9) ? 32'h1 : (c == 10) ? 32'h4 : 32'h2;
      chk("starve", rdy(), exp_r);
      tick();
      if (c == 9) chk("starve_alu_wr", 32'(rf_write_reg), 32'd9);
    end
    alu_valid = 1'b0; mem_valid = 1'b0; md_valid = 1'b0;
`endif

    // async reset mid-stream drops readies and clears state
    alu_valid = 1'b1; claim_valid = 1'b1; claim_reg = 5'd7; q_reg1 = 5'd7;
    tick();
    claim_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst2_ready", rdy(), 32'h0);
    chk("rst2_busy", 32'(q_busy1), 32'h0);
    chk("rst2_rf_write", 32'(rf_write), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive denied valid cycles after which a requester is promoted in fixed-priority mode (range 1..255).
REQ-002 SHALL have ports: clk  input  1  clock, rising-edge active; rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: alu_valid  input  1; alu_reg  input  5; alu_data  input  32; alu_ready  output  1 (ALU writeback requester).
REQ-004 SHALL have ports: mem_valid, mem_reg, mem_data, mem_ready, widths as REQ-003 (load writeback requester).
REQ-005 SHALL have ports: md_valid, md_reg, md_data, md_ready, widths as REQ-003 (mul/div writeback requester).
REQ-006 SHALL have ports: rf_write  output  1; rf_write_reg  output  5; rf_write_data  output  32 (drive the single register-file write port).
REQ-007 SHALL have ports: claim_valid  input  1; claim_reg  input  5 (issue stage reserves a destination).
REQ-008 SHALL have ports: q_reg1  input  5; q_reg2  input  5; q_busy1  output  1; q_busy2  output  1 (hazard query for decode).

Function
REQ-009 Handshake: a requester's transfer occurs in a cycle where valid and ready are both 1; valid, reg and data SHALL be held stable by the requester until that cycle.
REQ-010 At most one ready SHALL be 1 per cycle; ready SHALL be 0 for any requester whose valid is 0; ready is combinational from valids and arbiter state.
REQ-011 If any valid is 1, exactly one ready SHALL be 1 (arbiter never idles with pending requests).
REQ-012 Winner's reg/data SHALL be registered: rf_write=1, rf_write_reg, rf_write_data appear the cycle after the transfer (1-cycle latency); rf_write=0 in cycles after no transfer.
REQ-013 Transfer with reg=0 SHALL complete the handshake but SHALL produce rf_write=0 next cycle.
REQ-014 Fixed-priority mode: order mem > md > alu, except a requester whose starvation counter equals STARVE_LIMIT SHALL win; among several promoted, order mem > md > alu.
REQ-015 Starvation counter per requester: increments (saturating at STARVE_LIMIT) on each cycle valid=1 and ready=0; clears to 0 on transfer or valid=0.
REQ-016 Scoreboard: 31 busy bits for regs 1..31; reg 0 never busy.
REQ-017 claim_valid=1 with claim_reg!=0 SHALL set busy[claim_reg] at the clock edge; claim of reg 0 is ignored.
REQ-018 Transfer with reg!=0 SHALL clear busy[reg] at the same edge the output register loads.
REQ-019 Claim and clear of the same reg in one cycle: busy SHALL end 1 (claim wins).
REQ-020 q_busy1/q_busy2 SHALL be combinational: busy[q_regN], 0 when q_regN=0; a claim/clear is visible from the cycle after its edge.
REQ-021 Transfer to a reg not busy SHALL still be written; no error signalled.

Reset
REQ-022 rst=0 SHALL asynchronously force: rf_write=0, rf_write_reg=0, rf_write_data=0, all busy bits 0, all starvation counters 0, round-robin pointer to alu.
REQ-023 While rst=0 all ready outputs SHALL be 0; transfers in progress are dropped, not replayed.
REQ-024 After rst deasserts, first grant SHALL be possible on the first rising clk edge.

Configuration
REQ-025 Macro RF_WB_RR_EN: when defined, arbitration SHALL be round-robin over order alu -> mem -> md, starting search at the requester after the last winner; pointer updates only on transfer; starvation counters and STARVE_LIMIT unused.
REQ-026 RF_WB_RR_EN undefined: fixed priority with starvation promotion per REQ-014/015.

Verification
REQ-027 Reset: drive all valids 1 with rst=0 -> all ready 0, rf_write 0; release rst -> mem_ready=1 in first cycle (fixed mode).
REQ-028 Single write: alu_valid=1, alu_reg=5, alu_data=0x1234 -> alu_ready=1 same cycle; next cycle rf_write=1, rf_write_reg=5, rf_write_data=0x1234.
REQ-029 Starvation (fixed, STARVE_LIMIT=8): all three valid continuously, mem/md reasserted each transfer -> alu_ready=1 no later than the 9th cycle alu_valid is held.
REQ-030 Round-robin (RF_WB_RR_EN): all three valid continuously -> grant sequence alu, mem, md, alu, ...
REQ-031 Scoreboard: claim reg 7 -> q_busy1=1 for q_reg1=7 next cycle; md writes reg 7 with claim of reg 7 same cycle -> still busy; lone md write of reg 7 -> q_busy1=0 next cycle.
REQ-032 Reg 0: mem writes reg 0 -> mem_ready=1, next-cycle rf_write=0; claim reg 0 -> q_busy for reg 0 stays 0.
